// File: rtl/body_pkg.sv
// -----------------------------------------------------------------------------
// body_pkg
// Shared definitions for the snake-body LIFO.
//   BODY_WIDTH / BODY_DEPTH : default entry width and stack depth
//   dir_e                   : direction code stored per body segment
//   op_e / lifo_op()        : decode of the push/pop request pair
// -----------------------------------------------------------------------------
package body_pkg;

    localparam int BODY_WIDTH = 3;
    localparam int BODY_DEPTH = 64;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Encoding follows {pop, push} so the decode is a plain concatenation.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    function automatic op_e lifo_op(input logic push, input logic pop);
        return op_e'({pop, push});
    endfunction

endpackage

// File: rtl/body_lifo_mem.sv
// -----------------------------------------------------------------------------
// body_lifo_mem
// Storage array for body_lifo. Contents are never reset.
//   clk, reset      : clock, async active-high reset (random read register only)
//   we_i/waddr_i/wdata_i : single write port
//   raddr_i/rdata_o : combinational read of the stack top (pop path)
//   rd_idx_i/rd_lim_i/rd_data_o : optional registered random-access read,
//                     enabled by macro BODY_LIFO_RDPORT_EN; entries at or
//                     above rd_lim_i (current count) read as 0.
// -----------------------------------------------------------------------------
module body_lifo_mem
    import body_pkg::*;
#(
    parameter int WIDTH = BODY_WIDTH,
    parameter int DEPTH = BODY_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic [AW-1:0]    rd_idx_i,
    input  logic [CW-1:0]    rd_lim_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

`ifdef BODY_LIFO_RDPORT_EN
    logic [WIDTH-1:0] rd_data_q;

    // Reads the pre-edge contents, so a same-cycle write returns the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      rd_data_q <= '0;
        else if (CW'(rd_idx_i) < rd_lim_i) rd_data_q <= mem_q[rd_idx_i];
        else                            rd_data_q <= '0;
    end

    assign rd_data_o = rd_data_q;
`else
    logic unused_rd;
    assign unused_rd = ^{reset, rd_idx_i, rd_lim_i};
    assign rd_data_o = '0;
`endif

endmodule

// File: rtl/body_lifo.sv
// -----------------------------------------------------------------------------
// body_lifo
// LIFO of snake body segments with sticky error flags and an optional
// random-access read port (macro BODY_LIFO_RDPORT_EN).
//   clk, reset       : clock, async active-high reset
//   clear            : synchronous flush of count and flags (memory kept)
//   push/din         : write din on top
//   pop              : pop top into dout; dout_valid pulses one cycle
//   push+pop         : replace-top when non-empty
//   count/empty/full : occupancy, registered
//   overflow/underflow : sticky until clear/reset
//   rd_idx/rd_data   : random read (0 = bottom), registered, 0 if disabled
// -----------------------------------------------------------------------------
module body_lifo
    import body_pkg::*;
#(
    parameter int WIDTH = BODY_WIDTH,
    parameter int DEPTH = BODY_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             empty_q, full_q;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] top_data;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_addr = AW'(count_q - CW'(1));

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        we      = 1'b0;
        waddr   = AW'(count_q);

        unique case (lifo_op(push, pop))
            OP_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    dout_d  = top_data;
                    dv_d    = 1'b1;
                    count_d = count_q - CW'(1);
                end else begin
                    udf_d = 1'b1;
                end
            end
            OP_REPLACE: begin
                we = 1'b1;
                if (!is_empty) begin
                    // Old top goes out while the new value overwrites it.
                    waddr  = top_addr;
                    dout_d = top_data;
                    dv_d   = 1'b1;
                end else begin
                    // Nothing to pop: degrade to a plain push into slot 0.
                    count_d = CW'(1);
                    udf_d   = 1'b1;
                end
            end
            default: ;
        endcase

        if (clear) begin
            count_d = '0;
            dout_d  = dout_q;
            dv_d    = 1'b0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    body_lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (din),
        .raddr_i   (top_addr),
        .rdata_o   (top_data),
        .rd_idx_i  (rd_idx),
        .rd_lim_i  (count_q),
        .rd_data_o (rd_data)
    );

    assign count      = count_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_body_lifo.sv
module tb_body_lifo;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset, clear, push, pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty, full, overflow, underflow;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_data;

    body_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop),
        .din(din), .dout(dout), .dout_valid(dout_valid), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the stack as a queue (back = top).
    int stk[$];
    int m_dout;
    bit m_dv, m_ov, m_uf;
    int m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout = 0; m_dv = 0; m_ov = 0; m_uf = 0; m_rd = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     32'(count),      32'(stk.size()));
        chk({tag, ".empty"},     32'(empty),      32'(stk.size() == 0));
        chk({tag, ".full"},      32'(full),       32'(stk.size() == DEPTH));
        chk({tag, ".dout"},      32'(dout),       32'(m_dout));
        chk({tag, ".dvalid"},    32'(dout_valid), 32'(m_dv));
        chk({tag, ".overflow"},  32'(overflow),   32'(m_ov));
        chk({tag, ".underflow"}, 32'(underflow),  32'(m_uf));
`ifdef BODY_LIFO_RDPORT_EN
        chk({tag, ".rd_data"},   32'(rd_data),    32'(m_rd));
`else
        chk({tag, ".rd_data"},   32'(rd_data),    32'(0));
`endif
    endtask

    // One clock with the given request; model advances per the LIFO rules.
    task automatic cyc(input string tag, input bit p, input bit q, input bit c,
                       input logic [WIDTH-1:0] d, input logic [AW-1:0] r);
        push = p; pop = q; clear = c; din = d; rd_idx = r;
        m_rd = (int'(r) < stk.size()) ? stk[int'(r)] : 0;
        @(posedge clk); #1;
        m_dv = 0;
        if (c) begin
            stk.delete(); m_ov = 0; m_uf = 0;
        end else if (p && q) begin
            if (stk.size() > 0) begin
                m_dout = stk[stk.size()-1];
                stk[stk.size()-1] = int'(d);
                m_dv = 1;
            end else begin
                stk.push_back(int'(d));
                m_uf = 1;
            end
        end else if (p) begin
            if (stk.size() < DEPTH) stk.push_back(int'(d));
            else m_ov = 1;
        end else if (q) begin
            if (stk.size() > 0) begin
                m_dout = stk.pop_back();
                m_dv = 1;
            end else m_uf = 1;
        end
        push = 0; pop = 0; clear = 0;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; clear = 0; push = 0; pop = 0; din = '0; rd_idx = '0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // push 5,1,2 then pop
        cyc("p5", 1, 0, 0, 3'd5, 0);
        cyc("p1", 1, 0, 0, 3'd1, 0);
        cyc("p2", 1, 0, 0, 3'd2, 0);
        chk("three.count", 32'(count), 32'd3);
        cyc("pop2", 0, 1, 0, 0, 0);
        chk("pop2.dout", 32'(dout), 32'd2);
        chk("pop2.dv", 32'(dout_valid), 32'd1);
        cyc("idle", 0, 0, 0, 0, 0);
        cyc("pop1", 0, 1, 0, 0, 0);
        cyc("pop5", 0, 1, 0, 0, 0);

        // underflow on empty, then push+pop on empty
        cyc("udf", 0, 1, 0, 0, 0);
        chk("udf.flag", 32'(underflow), 32'd1);
        cyc("pp_empty", 1, 1, 0, 3'd4, 0);
        chk("pp_empty.count", 32'(count), 32'd1);
        chk("pp_empty.udf", 32'(underflow), 32'd1);
        cyc("clr1", 0, 0, 1, 0, 0);

        // replace-top on [3,6]
        cyc("p3", 1, 0, 0, 3'd3, 0);
        cyc("p6", 1, 0, 0, 3'd6, 0);
        cyc("rep7", 1, 1, 0, 3'd7, 0);
        chk("rep7.dout", 32'(dout), 32'd6);
        cyc("pop7", 0, 1, 0, 0, 0);
        chk("pop7.dout", 32'(dout), 32'd7);
        cyc("clr2", 0, 0, 1, 0, 0);

        // fill, overflow, pop last, replace at full
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 0, 0, 3'(i + 1), 0);
        chk("fill.full", 32'(full), 32'd1);
        cyc("ovf", 1, 0, 0, 3'd7, 0);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.count", 32'(count), 32'(DEPTH));
        cyc("pop_full", 0, 1, 0, 0, 0);
        chk("pop_full.dout", 32'(dout), 32'(DEPTH));
        cyc("refill", 1, 0, 0, 3'd6, 0);
        cyc("rep_full", 1, 1, 0, 3'd2, 0);
        cyc("clr3", 0, 0, 1, 0, 0);

        // random-access read on [1,2,3]
        cyc("r1", 1, 0, 0, 3'd1, 0);
        cyc("r2", 1, 0, 0, 3'd2, 0);
        cyc("r3", 1, 0, 0, 3'd3, 0);
        cyc("rd0", 0, 0, 0, 0, 2'd0);
        cyc("rd3", 0, 0, 0, 0, 2'd3);
        cyc("rd2", 1, 1, 0, 3'd5, 2'd2);   // same-cycle write returns old value
        cyc("rd2b", 0, 0, 0, 0, 2'd2);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                sel < 3, 3'($urandom), 2'($urandom));
        end

        // async reset in the middle of a push burst
        cyc("b1", 1, 0, 0, 3'd3, 0);
        cyc("b2", 1, 0, 0, 3'd4, 0);
        push = 1; din = 3'd5;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        push = 0;
        reset = 1'b0;
        #1;
        check_all("after_rst");

        // refill then clear
        cyc("f1", 1, 0, 0, 3'd1, 0);
        cyc("f2", 1, 0, 0, 3'd2, 0);
        cyc("f3", 0, 1, 0, 0, 0);
        cyc("f4", 0, 1, 0, 0, 0);
        cyc("f5", 0, 1, 0, 0, 0);
        cyc("clr_end", 0, 0, 1, 0, 0);
        chk("clr_end.empty", 32'(empty), 32'd1);
        chk("clr_end.udf", 32'(underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
